// File: rtl/auto_playlist_ctrl.sv
// Auto-play controller: song selection, playlist play modes and pause menu.
// Drives the note player core and the six-digit segment display.
module auto_playlist_ctrl #(
  parameter int         N_SONGS   = 8,
  parameter int         IDX_W     = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             prev_btn,
  input  logic             next_btn,
  input  logic             mode_btn,
  input  logic             confirm_btn,
  input  logic             pause_btn,
  input  logic             player_over,
  output logic [IDX_W-1:0] song_idx,
  output logic             player_run,
  output logic             player_restart,
  output logic             exit_pulse,
  output logic             twinkle,
  output logic [1:0]       state_o,
  output logic [1:0]       play_mode,
  output logic [5:0]       seg1,
  output logic [5:0]       seg2,
  output logic [5:0]       seg3,
  output logic [5:0]       seg4,
  output logic [5:0]       seg5,
  output logic [5:0]       seg6
);

  localparam logic [1:0] ST_SELECT = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  localparam logic [1:0] MODE_ONCE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_LOOP   = 2'd2;

  localparam logic [1:0] MENU_CONTINUE = 2'd0;
  localparam logic [1:0] MENU_RESTART  = 2'd1;
  localparam logic [1:0] MENU_RESELECT = 2'd2;

  localparam logic [5:0]       BLANK    = 6'h3F;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SONGS - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      idx_inc = ZERO_IDX;
    end else begin
      idx_inc = idx + IDX_W'(1'b1);
    end
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] idx);
    if (idx == ZERO_IDX) begin
      idx_dec = LAST_IDX;
    end else begin
      idx_dec = idx - IDX_W'(1'b1);
    end
  endfunction

  // Fibonacci taps 8,6,5,4: maximal length, so a non-zero seed never reaches 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    lfsr_step = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Random pick that is guaranteed to differ from the song just played
  function automatic logic [IDX_W-1:0] shuffle_pick(input logic [IDX_W-1:0] cur,
                                                    input logic [7:0]       l);
    logic [IDX_W-1:0] cand;
    cand = IDX_W'(l % 8'(N_SONGS));
    if (cand == cur) begin
      shuffle_pick = idx_inc(cand);
    end else begin
      shuffle_pick = cand;
    end
  endfunction

  function automatic logic [5:0] digit_tens(input logic [IDX_W-1:0] idx);
    logic [6:0] num;
    num        = 7'(idx) + 7'd1;
    digit_tens = 6'(num / 7'd10);
  endfunction

  function automatic logic [5:0] digit_ones(input logic [IDX_W-1:0] idx);
    logic [6:0] num;
    num        = 7'(idx) + 7'd1;
    digit_ones = 6'(num % 7'd10);
  endfunction

  logic [1:0]       state_r, state_s;
  logic [IDX_W-1:0] sel_r, sel_s;
  logic [IDX_W-1:0] song_r, song_s;
  logic [1:0]       mode_r, mode_s;
  logic [1:0]       menu_r, menu_s;
  logic [7:0]       lfsr_r;
  logic             restart_r, restart_s;
  logic             exit_r, exit_s;
  logic             run_r, twinkle_r;
  logic [IDX_W-1:0] shown_s;
  logic [5:0]       seg1_r, seg2_r, seg3_r, seg4_r, seg5_r, seg6_r, seg5_s;

  // Next-state and pulse decode for the SELECT / PLAY / PAUSE controller
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    song_s    = song_r;
    mode_s    = mode_r;
    menu_s    = menu_r;
    restart_s = 1'b0;
    exit_s    = 1'b0;
    if (!enable) begin
      state_s = ST_SELECT;
      sel_s   = ZERO_IDX;
      song_s  = ZERO_IDX;
      menu_s  = 2'd0;
    end else begin
      case (state_r)
        ST_SELECT: begin
          if (confirm_btn) begin
            song_s    = sel_r;
            restart_s = 1'b1;
            state_s   = ST_PLAY;
          end else if (mode_btn) begin
            mode_s = mode_r + 2'd1;
          end else if (next_btn) begin
            sel_s = idx_inc(sel_r);
          end else if (prev_btn) begin
            sel_s = idx_dec(sel_r);
          end else begin
            sel_s = sel_r;
          end
        end
        ST_PLAY: begin
          if (player_over) begin
            case (mode_r)
              MODE_ONCE: begin
                state_s = ST_SELECT;
                sel_s   = song_r;
              end
              MODE_REPEAT: restart_s = 1'b1;
              MODE_LOOP: begin
                song_s    = idx_inc(song_r);
                restart_s = 1'b1;
              end
              default: begin
                song_s    = shuffle_pick(song_r, lfsr_r);
                restart_s = 1'b1;
              end
            endcase
          end else if (next_btn) begin
            if (mode_r == MODE_LOOP || mode_r != 2'd3) begin
              song_s = idx_inc(song_r);
            end else begin
              song_s = shuffle_pick(song_r, lfsr_r);
            end
            restart_s = 1'b1;
          end else if (pause_btn) begin
            state_s = ST_PAUSE;
            menu_s  = 2'd0;
          end else begin
            state_s = state_r;
          end
        end
        ST_PAUSE: begin
          if (confirm_btn) begin
            case (menu_r)
              MENU_CONTINUE: state_s = ST_PLAY;
              MENU_RESTART: begin
                state_s   = ST_PLAY;
                restart_s = 1'b1;
              end
              MENU_RESELECT: begin
                state_s = ST_SELECT;
                sel_s   = song_r;
              end
              default: begin
                state_s = ST_SELECT;
                exit_s  = 1'b1;
              end
            endcase
          end else if (next_btn) begin
            menu_s = menu_r + 2'd1;
          end else begin
            menu_s = menu_r;
          end
        end
        default: state_s = ST_SELECT;
      endcase
    end

    if (state_s == ST_SELECT) begin
      shown_s = sel_s;
    end else begin
      shown_s = song_s;
    end
    if (state_s == ST_PAUSE) begin
      seg5_s = {4'b0000, menu_s};
    end else begin
      seg5_s = BLANK;
    end
  end

  // State, LFSR and registered outputs; display follows the new state in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_SELECT;
      sel_r     <= ZERO_IDX;
      song_r    <= ZERO_IDX;
      mode_r    <= MODE_ONCE;
      menu_r    <= 2'd0;
      lfsr_r    <= LFSR_SEED;
      restart_r <= 1'b0;
      exit_r    <= 1'b0;
      run_r     <= 1'b0;
      twinkle_r <= 1'b1;
      seg1_r    <= 6'd0;
      seg2_r    <= 6'd0;
      seg3_r    <= 6'd0;
      seg4_r    <= 6'd1;
      seg5_r    <= BLANK;
      seg6_r    <= BLANK;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      song_r    <= song_s;
      mode_r    <= mode_s;
      menu_r    <= menu_s;
      lfsr_r    <= lfsr_step(lfsr_r);
      restart_r <= restart_s;
      exit_r    <= exit_s;
      run_r     <= (state_s == ST_PLAY);
      twinkle_r <= (state_s == ST_SELECT);
      seg1_r    <= {4'b0000, state_s};
      seg2_r    <= {4'b0000, mode_s};
      seg3_r    <= digit_tens(shown_s);
      seg4_r    <= digit_ones(shown_s);
      seg5_r    <= seg5_s;
      seg6_r    <= BLANK;
    end
  end

  assign song_idx       = song_r;
  assign player_run     = run_r;
  assign player_restart = restart_r;
  assign exit_pulse     = exit_r;
  assign twinkle        = twinkle_r;
  assign state_o        = state_r;
  assign play_mode      = mode_r;
  assign seg1           = seg1_r;
  assign seg2           = seg2_r;
  assign seg3           = seg3_r;
  assign seg4           = seg4_r;
  assign seg5           = seg5_r;
  assign seg6           = seg6_r;

endmodule

// File: tb/tb_auto_playlist_ctrl.sv
// Scoreboard bench for auto_playlist_ctrl: a reference model queues the expected
// outputs each cycle and an independent monitor compares them against the DUT.
module tb_auto_playlist_ctrl;

  localparam int         N    = 8;
  localparam logic [7:0] SEED = 8'hA5;

  localparam logic [5:0] B_PREV    = 6'b000001;
  localparam logic [5:0] B_NEXT    = 6'b000010;
  localparam logic [5:0] B_MODE    = 6'b000100;
  localparam logic [5:0] B_CONFIRM = 6'b001000;
  localparam logic [5:0] B_PAUSE   = 6'b010000;
  localparam logic [5:0] B_OVER    = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [5:0] btn = 6'b000000;

  logic [2:0] song_idx;
  logic       player_run, player_restart, exit_pulse, twinkle;
  logic [1:0] state_o, play_mode;
  logic [5:0] seg1, seg2, seg3, seg4, seg5, seg6;

  auto_playlist_ctrl #(.N_SONGS(N), .IDX_W(3), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .prev_btn(btn[0]), .next_btn(btn[1]), .mode_btn(btn[2]),
    .confirm_btn(btn[3]), .pause_btn(btn[4]), .player_over(btn[5]),
    .song_idx(song_idx), .player_run(player_run), .player_restart(player_restart),
    .exit_pulse(exit_pulse), .twinkle(twinkle), .state_o(state_o), .play_mode(play_mode),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5), .seg6(seg6)
  );

  always #5 clk = ~clk;

  typedef struct {
    int song; int run; int restart; int exit_p; int tw;
    int st; int mode; int s1; int s2; int s3; int s4; int s5; int s6;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  // Reference model state (plain integers)
  int m_st = 0, m_sel = 0, m_song = 0, m_mode = 0, m_menu = 0;
  logic [7:0] m_lfsr = SEED;

  function automatic int shuffle(input int cur, input logic [7:0] l);
    int c;
    c = int'(l) % N;
    if (c == cur) c = (c + 1) % N;
    return c;
  endfunction

  // Reference model: one expected output record per clock edge
  initial begin
    forever begin
      exp_t e;
      int rs, ex, shown;
      logic [7:0] old;
      @(posedge clk);
      rs = 0; ex = 0;
      if (rst) begin
        m_st = 0; m_sel = 0; m_song = 0; m_mode = 0; m_menu = 0; m_lfsr = SEED;
      end else begin
        old = m_lfsr;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (!enable) begin
          m_st = 0; m_sel = 0; m_song = 0; m_menu = 0;
        end else if (m_st == 0) begin
          if (btn[3]) begin m_song = m_sel; rs = 1; m_st = 1; end
          else if (btn[2]) m_mode = (m_mode + 1) % 4;
          else if (btn[1]) m_sel = (m_sel + 1) % N;
          else if (btn[0]) m_sel = (m_sel + N - 1) % N;
        end else if (m_st == 1) begin
          if (btn[5]) begin
            if (m_mode == 0) begin m_st = 0; m_sel = m_song; end
            else begin
              if (m_mode == 2) m_song = (m_song + 1) % N;
              else if (m_mode == 3) m_song = shuffle(m_song, old);
              rs = 1;
            end
          end else if (btn[1]) begin
            m_song = (m_mode == 3) ? shuffle(m_song, old) : (m_song + 1) % N;
            rs = 1;
          end else if (btn[4]) begin
            m_st = 2; m_menu = 0;
          end
        end else begin
          if (btn[3]) begin
            case (m_menu)
              0: m_st = 1;
              1: begin m_st = 1; rs = 1; end
              2: begin m_st = 0; m_sel = m_song; end
              default: begin m_st = 0; ex = 1; end
            endcase
          end else if (btn[1]) m_menu = (m_menu + 1) % 4;
        end
      end
      shown = (m_st == 0) ? m_sel : m_song;
      e.song = m_song; e.run = (m_st == 1); e.restart = rs; e.exit_p = ex;
      e.tw = (m_st == 0); e.st = m_st; e.mode = m_mode;
      e.s1 = m_st; e.s2 = m_mode; e.s3 = (shown + 1) / 10; e.s4 = (shown + 1) % 10;
      e.s5 = (m_st == 2) ? m_menu : 63; e.s6 = 63;
      q.push_back(e);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: pops the expected record and compares after each edge settles
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (!done && q.size() > 0) begin
        e = q.pop_front();
        chk("song_idx", int'(song_idx), e.song);
        chk("player_run", int'(player_run), e.run);
        chk("player_restart", int'(player_restart), e.restart);
        chk("exit_pulse", int'(exit_pulse), e.exit_p);
        chk("twinkle", int'(twinkle), e.tw);
        chk("state_o", int'(state_o), e.st);
        chk("play_mode", int'(play_mode), e.mode);
        chk("seg1", int'(seg1), e.s1);
        chk("seg2", int'(seg2), e.s2);
        chk("seg3", int'(seg3), e.s3);
        chk("seg4", int'(seg4), e.s4);
        chk("seg5", int'(seg5), e.s5);
        chk("seg6", int'(seg6), e.s6);
        chk("song_idx_range", int'(song_idx < 3'(N - 1) || song_idx == 3'(N - 1)), 1);
      end
    end
  end

  task automatic drive(input logic [5:0] b);
    @(negedge clk);
    btn = b;
  endtask

  task automatic press(input logic [5:0] b);
    drive(b);
    drive(6'b000000);
  endtask

  task automatic press_n(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(6'b000000);
    // Select song 2 and start it
    press_n(B_NEXT, 3);
    press(B_PREV);
    press(B_CONFIRM);
    // Pause menu RESELECT
    press(B_PAUSE);
    press_n(B_NEXT, 2);
    press(B_CONFIRM);
    // Index wrap in both directions, then play song 7 in ONCE
    press_n(B_PREV, 3);
    press(B_NEXT);
    press(B_PREV);
    press(B_CONFIRM);
    repeat (3) drive(6'b000000);
    press(B_OVER);
    // LOOP_ALL wrap from 7, then over+pause together
    press_n(B_MODE, 2);
    press(B_CONFIRM);
    press(B_OVER);
    press(B_OVER | B_PAUSE);
    // Pause menu EXIT
    press(B_PAUSE);
    press_n(B_NEXT, 3);
    press(B_CONFIRM);
    // SHUFFLE with 200 song-end pulses
    press(B_MODE);
    press(B_CONFIRM);
    for (int i = 0; i < 200; i++) begin
      press(B_OVER);
      repeat ($urandom_range(0, 2)) drive(6'b000000);
    end
    // enable low mid-song
    @(negedge clk);
    enable = 1'b0;
    repeat (2) drive(6'b000000);
    enable = 1'b1;
    press(B_CONFIRM);
    // Randomized traffic with occasional enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] b;
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 5) == 0);
      drive(b);
      enable = ($urandom_range(0, 49) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    drive(6'b000000);
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
